cnn_layer_sequencer: RTL and testbench
======================================

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 Parameters SHALL be: CONV_DIM, default 24, conv output rows/cols; POOL_DIM, default 12, pool output rows/cols; NUM_CLASSES, default 10, FC outputs; PROB_W, default 32, probability width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 enable  input  1  start request; sampled only in IDLE.
REQ-006 abort  input  1  cancel the current inference.
REQ-007 dp_ready  input  1  datapath accepts the current issue this cycle (stall when low).
REQ-008 conv_en  output  1  conv issue valid.
REQ-009 conv_row, conv_col  output  5 each  conv window origin, 0..CONV_DIM-1.
REQ-010 pool_en  output  1  pool issue valid.
REQ-011 pool_row, pool_col  output  4 each  pool output coordinate, 0..POOL_DIM-1.
REQ-012 fc_en  output  1  FC neuron issue valid.
REQ-013 fc_idx  output  4  FC neuron index, 0..NUM_CLASSES-1.
REQ-014 prob_valid  input  1  prob_in is valid; arrivals are in fc_idx order.
REQ-015 prob_in  input  PROB_W  signed two's-complement class score.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when result is updated.
REQ-018 result  output  4  index of the winning class; held until the next done.

Function
REQ-019 The FSM SHALL have states IDLE, CONV, POOL, FC, WAIT_FC and DONE.
REQ-020 IDLE SHALL go to CONV on the first edge with enable=1, clearing all counters and the argmax registers.
REQ-021 In CONV, conv_en=1 every cycle; on dp_ready=1 the coordinate SHALL advance column-major-inner (col, then row); on dp_ready=0 it SHALL hold.
REQ-022 The accepted issue at (CONV_DIM-1, CONV_DIM-1) SHALL move the FSM to POOL, giving exactly CONV_DIM^2 accepted issues.
REQ-023 POOL SHALL follow the same rules over POOL_DIM^2 coordinates and then move to FC.
REQ-024 FC SHALL issue fc_idx 0..NUM_CLASSES-1 using the same dp_ready rule and then move to WAIT_FC.
REQ-025 Only the current stage's *_en SHALL be high; the others SHALL be 0.
REQ-026 Idle coordinate outputs SHALL be 0.
REQ-027 prob_valid SHALL be accepted in FC and in WAIT_FC; it SHALL be ignored in all other states.
REQ-028 The block SHALL track max_val and max_idx over accepted prob_valid arrivals.
REQ-029 The first arrival SHALL load max_val and max_idx unconditionally.
REQ-030 A later arrival SHALL replace the maximum only if it is strictly greater in signed compare, so ties go to the lowest index.
REQ-031 On the NUM_CLASSES-th arrival, the FSM SHALL go to DONE (directly from FC if needed), and that arrival SHALL be included in the compare.
REQ-032 DONE SHALL last one cycle: done=1 and result<=max_idx on entry, then the FSM returns to IDLE.
REQ-033 enable while busy SHALL be ignored, with no queuing.
REQ-034 enable held high through DONE SHALL restart on the first IDLE cycle.
REQ-035 abort=1 in any busy state SHALL return the FSM to IDLE on the next edge with no done pulse and result unchanged.
REQ-036 abort SHALL take priority over every other transition.
REQ-037 In IDLE, abort SHALL have no effect.
REQ-038 The FSM SHALL ignore more than NUM_CLASSES prob_valid pulses after DONE.

Reset
REQ-039 rst=1 SHALL take effect at the next edge: state=IDLE, all counters=0, all *_en=0, busy=0, done=0, result=0, max_val=0, max_idx=0.
REQ-040 Reset SHALL override abort and enable.
REQ-041 Reset asserted mid-inference SHALL discard the inference with no done pulse.

Structure
REQ-042 Package cnn_pkg SHALL hold the state enum, the CONV_DIM, POOL_DIM and NUM_CLASSES defaults, and the coordinate widths shared with the conv, pool and FC datapath.
REQ-043 A sub-module cnn_argmax SHALL implement the max tracking, with inputs clear, valid and value and outputs max_idx and count.
REQ-044 The 2-D counter SHALL be a local reusable always-block pattern, not a separate module.

Verification
REQ-045 Scenario 1, no-stall run: rst 2 cycles, enable pulse, dp_ready=1, prob_valid 1 cycle after each fc_en.
- Response: conv_en high for 576 cycles, then pool_en for 144, then fc_en for 10.
- Response: done pulses once, busy falls the cycle after done.
REQ-046 Scenario 2, argmax: prob_in sequence 5,-3,9,9,2,0,1,-7,8,4 -> result=2 (tie at index 3 loses).
- Same scenario with all values negative (-10..-1 ascending) -> result=9.
REQ-047 Scenario 3, stall: dp_ready toggles 1,0 every cycle.
- Response: coordinates hold during stalls, conv phase takes 1151 cycles, no coordinate is skipped or repeated (scoreboard all 576).
REQ-048 Scenario 4, abort: abort at conv (10,3) -> IDLE next cycle, done never pulses, result retains its previous value.
- A fresh enable then starts at (0,0).
REQ-049 Scenario 5, reset mid-operation: rst asserted during POOL -> all outputs at reset values on the next edge.
- 12 later prob_valid pulses do not change result.
REQ-050 Scenario 6, busy start: enable asserted during FC is ignored; after DONE with enable held high, the next run starts on the first IDLE cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding, layer geometry defaults and coordinate widths
package cnn_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_POOL, S_FC, S_WAIT_FC, S_DONE
  } state_t;
  localparam int CONV_DIM_DEF    = 24;
  localparam int POOL_DIM_DEF    = 12;
  localparam int NUM_CLASSES_DEF = 10;
  localparam int CONV_W = 5;
  localparam int POOL_W = 4;
  localparam int FC_W   = 4;
endpackage

// File: rtl/cnn_argmax.sv
// cnn_argmax: running signed maximum over arrivals, ties kept by the lowest index
module cnn_argmax
  import cnn_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                valid,
  input  logic signed [W-1:0] value,
  output logic [FC_W-1:0]     max_idx,
  output logic [FC_W-1:0]     count
);
  logic signed [W-1:0] max_val;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_val <= '0;
      max_idx <= '0;
      count   <= '0;
    end else if (valid) begin
      if (count == '0 || value > max_val) begin
        max_val <= value;
        max_idx <= count;
      end
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: walks conv, pool and FC issue spaces, then reports the argmax class
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int CONV_DIM    = CONV_DIM_DEF,
  parameter int POOL_DIM    = POOL_DIM_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int PROB_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     abort,
  input  logic                     dp_ready,
  output logic                     conv_en,
  output logic [CONV_W-1:0]        conv_row,
  output logic [CONV_W-1:0]        conv_col,
  output logic                     pool_en,
  output logic [POOL_W-1:0]        pool_row,
  output logic [POOL_W-1:0]        pool_col,
  output logic                     fc_en,
  output logic [FC_W-1:0]          fc_idx,
  input  logic                     prob_valid,
  input  logic signed [PROB_W-1:0] prob_in,
  output logic                     busy,
  output logic                     done,
  output logic [FC_W-1:0]          result
);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_DIM - 1);
  localparam logic [POOL_W-1:0] POOL_LAST = POOL_W'(POOL_DIM - 1);
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(NUM_CLASSES - 1);
  state_t          state;
  logic [FC_W-1:0] max_idx, count, result_q;
  logic            take, last_take, start;
  assign take      = prob_valid && (state == S_FC || state == S_WAIT_FC);
  assign last_take = take && count == FC_LAST;
  assign start     = state == S_IDLE && enable;
  assign conv_en   = state == S_CONV;
  assign pool_en   = state == S_POOL;
  assign fc_en     = state == S_FC;
  assign busy      = state != S_IDLE;
  assign done      = state == S_DONE;
  // the winning index is visible in the same cycle as the done pulse, then held
  assign result    = done ? max_idx : result_q;
  cnn_argmax #(.W(PROB_W)) u_argmax (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .valid  (take),
    .value  (prob_in),
    .max_idx(max_idx),
    .count  (count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      conv_row <= '0;
      conv_col <= '0;
      pool_row <= '0;
      pool_col <= '0;
      fc_idx   <= '0;
      result_q <= '0;
    end else if (abort && busy) begin
      state    <= S_IDLE;
      conv_row <= '0;
      conv_col <= '0;
      pool_row <= '0;
      pool_col <= '0;
      fc_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: if (enable) begin
          state    <= S_CONV;
          conv_row <= '0;
          conv_col <= '0;
          pool_row <= '0;
          pool_col <= '0;
          fc_idx   <= '0;
        end
        S_CONV: if (dp_ready) begin
          conv_col <= conv_col == CONV_LAST ? '0 : conv_col + 1'b1;
          if (conv_col == CONV_LAST) conv_row <= conv_row == CONV_LAST ? '0 : conv_row + 1'b1;
          if (conv_col == CONV_LAST && conv_row == CONV_LAST) state <= S_POOL;
        end
        S_POOL: if (dp_ready) begin
          pool_col <= pool_col == POOL_LAST ? '0 : pool_col + 1'b1;
          if (pool_col == POOL_LAST) pool_row <= pool_row == POOL_LAST ? '0 : pool_row + 1'b1;
          if (pool_col == POOL_LAST && pool_row == POOL_LAST) state <= S_FC;
        end
        S_FC: if (last_take) begin
          state  <= S_DONE;
          fc_idx <= '0;
        end else if (dp_ready) begin
          fc_idx <= fc_idx == FC_LAST ? '0 : fc_idx + 1'b1;
          if (fc_idx == FC_LAST) state <= S_WAIT_FC;
        end
        S_WAIT_FC: if (last_take) state <= S_DONE;
        S_DONE: begin
          result_q <= max_idx;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed runs with hand-computed argmax and issue counts
module tb_cnn_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst, enable, abort, dp_ready, prob_valid;
  logic [31:0] prob_in;
  logic        conv_en, pool_en, fc_en, busy, done;
  logic [4:0]  conv_row, conv_col;
  logic [3:0]  pool_row, pool_col, fc_idx, result;
  int n_cmp = 0, n_err = 0;
  int vals[10];
  int conv_cyc, pool_cyc, fc_cyc, done_cnt, res_seen, bad, nseen, busy_at_done;
  bit seen[576];
  always #5 clk = ~clk;
  cnn_layer_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .abort(abort), .dp_ready(dp_ready),
    .conv_en(conv_en), .conv_row(conv_row), .conv_col(conv_col),
    .pool_en(pool_en), .pool_row(pool_row), .pool_col(pool_col),
    .fc_en(fc_en), .fc_idx(fc_idx), .prob_valid(prob_valid), .prob_in(prob_in),
    .busy(busy), .done(done), .result(result)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic run_inf(input bit stall, input bit hold_en);
    int cr = 0, cc = 0, pr = 0, pc = 0, fi = 0, pidx = 0;
    bit pend = 0, nd, got = 0;
    conv_cyc = 0; pool_cyc = 0; fc_cyc = 0; done_cnt = 0; bad = 0; nseen = 0;
    res_seen = 0; busy_at_done = 0;
    foreach (seen[i]) seen[i] = 0;
    enable = 1; dp_ready = 1; prob_valid = 0;
    @(negedge clk);
    enable = 0;
    for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
      nd = stall ? (cyc % 2 == 0) : 1'b1;
      if (done) begin done_cnt++; res_seen = result; busy_at_done = busy; got = 1; end
      if (conv_en) begin
        conv_cyc++;
        if (pool_en || fc_en) bad++;
        if (nd) begin
          if (conv_row != cr || conv_col != cc) bad++;
          if (conv_row < 24 && conv_col < 24) begin
            if (seen[int'(conv_row) * 24 + int'(conv_col)]) bad++;
            seen[int'(conv_row) * 24 + int'(conv_col)] = 1;
            nseen++;
          end
          cc++; if (cc == 24) begin cc = 0; cr++; end
        end
      end else if (conv_row != 0 || conv_col != 0) bad++;
      if (pool_en) begin
        pool_cyc++;
        if (conv_en || fc_en) bad++;
        if (nd) begin
          if (pool_row != pr || pool_col != pc) bad++;
          pc++; if (pc == 12) begin pc = 0; pr++; end
        end
      end else if (pool_row != 0 || pool_col != 0) bad++;
      if (fc_en) begin
        fc_cyc++;
        if (conv_en || pool_en) bad++;
        if (nd) begin if (fc_idx != fi) bad++; fi++; end
      end else if (fc_idx != 0) bad++;
      prob_valid = pend;
      prob_in = vals[pidx];
      pend = fc_en && nd;
      pidx = fc_idx < 10 ? int'(fc_idx) : 0;
      if (hold_en && fc_en) enable = 1;
      dp_ready = nd;
      @(negedge clk);
    end
    prob_valid = 0;
    check("done_seen", got, 1);
    check("done_busy", busy_at_done, 1);
    check("busy_after_done", busy, 0);
    check("issue_order", bad, 0);
  endtask
  initial begin
    int k;
    bit hit;
    rst = 1; enable = 0; abort = 0; dp_ready = 0; prob_valid = 0; prob_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_conv_en", conv_en, 0);
    check("rst_coords", {conv_row, conv_col, pool_row, pool_col, fc_idx}, 0);
    rst = 0;
    vals = '{5, -3, 9, 9, 2, 0, 1, -7, 8, 4};
    run_inf(0, 0);
    check("s1_conv_cycles", conv_cyc, 576);
    check("s1_pool_cycles", pool_cyc, 144);
    check("s1_fc_cycles", fc_cyc, 10);
    check("s1_done_count", done_cnt, 1);
    check("s2_result_tie", res_seen, 2);
    check("s2_result_held", result, 2);
    vals = '{-10, -9, -8, -7, -6, -5, -4, -3, -2, -1};
    run_inf(0, 0);
    check("s2_result_neg", res_seen, 9);
    vals = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    run_inf(1, 0);
    check("s3_conv_cycles", conv_cyc, 1151);
    check("s3_conv_unique", nseen, 576);
    check("s3_result", res_seen, 5);
    enable = 1; dp_ready = 1;
    @(negedge clk);
    enable = 0;
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (conv_row == 10 && conv_col == 3) hit = 1;
      else @(negedge clk);
    end
    check("s4_reached", hit, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("s4_busy", busy, 0);
    check("s4_conv_en", conv_en, 0);
    check("s4_coords", {conv_row, conv_col}, 0);
    k = 0;
    repeat (5) begin if (done) k++; @(negedge clk); end
    check("s4_no_done", k, 0);
    check("s4_result_kept", result, 5);
    enable = 1;
    @(negedge clk);
    enable = 0;
    check("s4_restart_en", conv_en, 1);
    check("s4_restart_origin", {conv_row, conv_col}, 0);
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (pool_en && pool_row == 2) hit = 1;
      else @(negedge clk);
    end
    check("s5_in_pool", hit, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("s5_outputs", {conv_en, pool_en, fc_en, busy, done}, 0);
    check("s5_coords", {conv_row, conv_col, pool_row, pool_col, fc_idx}, 0);
    check("s5_result", result, 0);
    k = 0;
    for (int i = 0; i < 24; i++) begin
      prob_valid = (i % 2 == 0);
      prob_in = 32'(100 + i);
      if (done) k++;
      @(negedge clk);
    end
    prob_valid = 0;
    check("s5_prob_ignored", result, 0);
    check("s5_no_done", k, 0);
    vals = '{0, 0, 0, 0, 0, 0, 0, 7, 0, 0};
    run_inf(0, 1);
    check("s6_done_count", done_cnt, 1);
    check("s6_fc_cycles", fc_cyc, 10);
    check("s6_result", res_seen, 7);
    @(negedge clk);
    enable = 0;
    check("s6_restart_en", conv_en, 1);
    check("s6_restart_origin", {conv_row, conv_col}, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("s6_abort_idle", busy, 0);
    check("s6_result_kept", result, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
